addr_decode_seq: RTL and testbench

ADDR_DECODE_SEQ -- requirements
Module: addr_decode_seq

---
 rtl/addr_decode_seq.sv | 136 +++++++++++++
 tb/tb_addr_decode_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/addr_decode_seq.sv
// rtl/addr_decode_seq.sv - one-hot address decoder with ack wait, timeout and error counting
module addr_decode_seq #(
    parameter int ADDR_W  = 3,
    parameter int NUM_SEL = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               req_ready,
    input  logic [NUM_SEL-1:0] ack,
    output logic [NUM_SEL-1:0] sel_x,
    output logic               done,
    output logic [1:0]         err_code,
    output logic [7:0]         err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          ADDR_SPAN = 2 ** ADDR_W;
    localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [1:0]  CODE_OK   = 2'b00;
    localparam logic [1:0]  CODE_DEC  = 2'b01;
    localparam logic [1:0]  CODE_TMO  = 2'b10;

    state_t               state_q, state_d;
    logic [NUM_SEL-1:0]   sel_q, sel_d;
    logic [7:0]           timer_q, timer_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic [NUM_SEL-1:0]   addr_dec;
    logic [ADDR_SPAN-1:0] ack_ext;
    logic                 addr_in_range;
    logic                 ack_hit;
    logic                 err_event;

    always_comb begin
        addr_dec = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            addr_dec[i] = (req_addr == ADDR_W'(i));
        end
        addr_in_range = (9'(req_addr) < 9'(NUM_SEL));
    end

    // Zero-extend ack to the full address span so the latched address always indexes in range.
    always_comb begin
        ack_ext              = '0;
        ack_ext[NUM_SEL-1:0] = ack;
        ack_hit              = ack_ext[addr_q];
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        timer_d    = timer_q;
        addr_d     = addr_q;
        err_code_d = err_code_q;
        err_event  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    timer_d = 8'd0;
                    if (addr_in_range) begin
                        state_d = WAIT;
                        sel_d   = addr_dec;
                    end else begin
                        state_d    = RESP;
                        err_code_d = CODE_DEC;
                        err_event  = 1'b1;
                    end
                end
            end
            WAIT: begin
                // Ack is checked before the timer so a same-cycle ack wins.
                if (ack_hit) begin
                    state_d    = RESP;
                    sel_d      = '0;
                    err_code_d = CODE_OK;
                end else if (timer_q == TMO_LAST) begin
                    state_d    = RESP;
                    sel_d      = '0;
                    err_code_d = CODE_TMO;
                    err_event  = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase

        err_cnt_d = err_cnt_q;
        if (err_event && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            timer_q    <= 8'd0;
            addr_q     <= '0;
            err_code_q <= CODE_OK;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            timer_q    <= timer_d;
            addr_q     <= addr_d;
            err_code_q <= err_code_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign done      = (state_q == RESP);
    assign sel_x     = sel_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_addr_decode_seq.sv
// tb/tb_addr_decode_seq.sv - table-driven bench for addr_decode_seq
module tb_addr_decode_seq;

    logic       clk;
    logic       rst_n;

    logic       req_valid;
    logic [2:0] req_addr;
    logic       req_ready;
    logic [7:0] ack;
    logic [7:0] sel_x;
    logic       done;
    logic [1:0] err_code;
    logic [7:0] err_cnt;

    logic       req_valid6;
    logic [2:0] req_addr6;
    logic       req_ready6;
    logic [5:0] ack6;
    logic [5:0] sel_x6;
    logic       done6;
    logic [1:0] err_code6;
    logic [7:0] err_cnt6;

    int tests;
    int failed;

    addr_decode_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .ack       (ack),
        .sel_x     (sel_x),
        .done      (done),
        .err_code  (err_code),
        .err_cnt   (err_cnt)
    );

    addr_decode_seq #(.ADDR_W(3), .NUM_SEL(6), .TIMEOUT(15)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid6),
        .req_addr  (req_addr6),
        .req_ready (req_ready6),
        .ack       (ack6),
        .sel_x     (sel_x6),
        .done      (done6),
        .err_code  (err_code6),
        .err_cnt   (err_cnt6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] addr;
        int         ack_at;
        int         ack_bit;
        int         noise_at;
        int         noise_bit;
        logic [1:0] exp_code;
        logic [7:0] exp_sel;
        int         exp_cycles;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         cycles;
        int         w;
        bit         got_done;
        bit         onehot;
        logic [7:0] seen;
        logic [1:0] code;
        cycles   = 0;
        got_done = 1'b0;
        onehot   = 1'b1;
        seen     = 8'h00;
        code     = 2'b11;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = v.addr;
        check($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 40 && !got_done; k++) begin
            if (done) begin
                got_done = 1'b1;
                code     = err_code;
                check($sformatf("v%0d sel_at_done", idx), 32'(sel_x), 32'd0);
            end else begin
                if (sel_x != 8'h00) begin
                    cycles++;
                    seen = sel_x;
                end
                if ($countones(sel_x) > 1) onehot = 1'b0;
                w   = cycles - 1;
                ack = 8'h00;
                if (w == v.ack_at)   ack[v.ack_bit]   = 1'b1;
                if (w == v.noise_at) ack[v.noise_bit] = 1'b1;
                @(negedge clk);
            end
        end
        ack = 8'h00;
        check($sformatf("v%0d done_seen", idx), 32'(got_done), 32'd1);
        check($sformatf("v%0d err_code", idx), 32'(code), 32'(v.exp_code));
        check($sformatf("v%0d sel_value", idx), 32'(seen), 32'(v.exp_sel));
        check($sformatf("v%0d sel_cycles", idx), 32'(cycles), 32'(v.exp_cycles));
        check($sformatf("v%0d err_cnt", idx), 32'(err_cnt), 32'(v.exp_cnt));
        check($sformatf("v%0d onehot", idx), 32'(onehot), 32'd1);
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 3'd0;
        ack        = 8'h00;
        req_valid6 = 1'b0;
        req_addr6  = 3'd0;
        ack6       = 6'h00;

        //           addr ack_at bit noise_at bit code   sel    cyc cnt
        vecs[0] = '{3'd5,  0, 5, -1, 0, 2'b00, 8'h20,  1, 8'd0};
        vecs[1] = '{3'd2, -1, 0, -1, 0, 2'b10, 8'h04, 15, 8'd1};
        vecs[2] = '{3'd3, 14, 3,  2, 4, 2'b00, 8'h08, 15, 8'd1};
        vecs[3] = '{3'd0,  3, 0, -1, 0, 2'b00, 8'h01,  4, 8'd1};
        vecs[4] = '{3'd7, -1, 0,  1, 6, 2'b10, 8'h80, 15, 8'd2};
        vecs[5] = '{3'd1,  7, 1,  0, 0, 2'b00, 8'h02,  8, 8'd2};

        #12;
        check("rst ready",   32'(req_ready), 32'd1);
        check("rst sel",     32'(sel_x),     32'd0);
        check("rst done",    32'(done),      32'd0);
        check("rst err_cnt", 32'(err_cnt),   32'd0);
        check("rst6 sel",    32'(sel_x6),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Decode error on the narrower instance, then a back-to-back request held through RESP.
        @(negedge clk);
        req_valid6 = 1'b1;
        req_addr6  = 3'd7;
        check("d6 ready", 32'(req_ready6), 32'd1);
        @(negedge clk);
        req_addr6 = 3'd6;
        check("d6 done",     32'(done6),     32'd1);
        check("d6 sel",      32'(sel_x6),    32'd0);
        check("d6 code",     32'(err_code6), 32'd1);
        check("d6 err_cnt",  32'(err_cnt6),  32'd1);
        @(negedge clk);
        check("d6 idle ready", 32'(req_ready6), 32'd1);
        check("d6 idle done",  32'(done6),      32'd0);
        @(negedge clk);
        check("d6 b2b done",    32'(done6),     32'd1);
        check("d6 b2b code",    32'(err_code6), 32'd1);
        check("d6 b2b err_cnt", 32'(err_cnt6),  32'd2);

        // Keep requesting bad addresses: one error every two cycles until saturation.
        repeat (2 * 252) @(negedge clk);
        check("sat 254", 32'(err_cnt6), 32'd254);
        repeat (2) @(negedge clk);
        check("sat 255", 32'(err_cnt6), 32'd255);
        check("sat done", 32'(done6), 32'd1);
        repeat (10) @(negedge clk);
        check("sat hold", 32'(err_cnt6), 32'd255);
        req_valid6 = 1'b0;

        // Reset in the middle of a WAIT on address 7.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 3'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid sel", 32'(sel_x), 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        check("async sel",  32'(sel_x),   32'd0);
        check("async done", 32'(done),    32'd0);
        @(negedge clk);
        check("rst hold done", 32'(done), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post ready",   32'(req_ready), 32'd1);
        check("post err_cnt", 32'(err_cnt),   32'd0);
        repeat (3) begin
            @(negedge clk);
            check("post no done", 32'(done), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
